rr_priority_arbiter: RTL and testbench

//  N-requester arbiter, parametrised successor of the 8-bit MSB-first one-hot priority encoder.

---
 rtl/arb_pkg.sv | 9 +
 rtl/priority_pick.sv | 20 ++
 rtl/rr_priority_arbiter.sv | 107 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and mode encodings for the round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/priority_pick.sv
// Combinational picker: one-hot of the highest set bit of 'in', zero when 'in' is empty.
module priority_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] in,
  output logic [N-1:0] out
);

  // Ascending scan so the last (highest) set bit overwrites any lower one.
  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i]) begin
        out    = '0;
        out[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-requester arbiter with a registered one-hot grant, held until ack or request drop,
// selecting by fixed MSB-first priority or round-robin from a runtime mode input.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic [N-1:0]     req,
  input  logic             ack,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;

  logic             arbitrate;
  logic [N-1:0]     cand;
  logic [N-1:0]     rot;
  logic [N-1:0]     pick;
  logic [N-1:0]     win;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] k;
  int               shamt;

  // Rotating right by ptr+1 lands ptr on the top bit, so the highest-bit picker
  // searches ptr, ptr-1, ..., 0, N-1, ..., ptr+1; a zero shift gives fixed priority.
  always_comb begin
    arbitrate = 1'b0;
    cand      = '0;
    shamt     = 0;
    rot       = '0;
    win       = '0;
    win_idx   = '0;
    k         = '0;

    case (state)
      ARB_IDLE: begin
        arbitrate = 1'b1;
        cand      = req;
      end
      ARB_GRANT: begin
        arbitrate = ack || !(|(req & gnt));
        cand      = req & ~gnt;
      end
      default: ;
    endcase

    case (mode)
      MODE_FIXED: shamt = 0;
      MODE_RR:    shamt = int'(ptr) + 1;
      default:    shamt = 0;
    endcase

    for (int j = 0; j < N; j++) begin
      k      = IDX_W'((j + shamt) % N);
      rot[j] = cand[k];
    end

    for (int j = 0; j < N; j++) begin
      k      = IDX_W'((j + shamt) % N);
      win[k] = pick[j];
    end

    for (int i = 0; i < N; i++) begin
      if (win[i]) win_idx = IDX_W'(i);
    end

    ptr_next = (win_idx == '0) ? IDX_W'(N - 1) : (win_idx - IDX_W'(1));
  end

  priority_pick #(.N(N)) u_pick (
    .in  (rot),
    .out (pick)
  );

  // Outputs only change at arbitration edges; an empty candidate set returns to idle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      ptr       <= IDX_W'(N - 1);
    end else if (arbitrate) begin
      if (|win) begin
        state     <= ARB_GRANT;
        gnt       <= win;
        gnt_valid <= 1'b1;
        gnt_idx   <= win_idx;
        ptr       <= ptr_next;
      end else begin
        state     <= ARB_IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_idx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Self-checking bench: directed scenarios pinned by literals, then randomized traffic
// compared every cycle against a behavioural arbiter model with an RR fairness watch.
module tb_rr_priority_arbiter;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             mode;
  logic [N-1:0]     req;
  logic             ack;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  int checks   = 0;
  int failures = 0;

  int model_cur = -1;
  int model_ptr = N - 1;
  int wait_cnt [N];
  bit cmp_en   = 1'b0;
  bit rr_phase = 1'b0;

  rr_priority_arbiter #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .req       (req),
    .ack       (ack),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always #5 clk = ~clk;

  function automatic int pickWinner(logic [N-1:0] c, logic m, int p);
    if (m == 1'b0) begin
      for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int s = 0; s < N; s++) begin
        int idx;
        idx = (p - s + N) % N;
        if (c[idx]) return idx;
      end
    end
    return -1;
  endfunction

  // Reference model: current grantee as an integer (-1 idle) plus the RR pointer.
  always @(posedge clk) begin
    if (!reset_n) begin
      model_cur = -1;
      model_ptr = N - 1;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      logic [N-1:0] c;
      bit           arb;
      int           w;
      c   = req;
      arb = 1'b1;
      if (model_cur >= 0) begin
        if (ack || !req[model_cur]) c[model_cur] = 1'b0;
        else arb = 1'b0;
      end
      for (int i = 0; i < N; i++) if (!req[i] || !rr_phase) wait_cnt[i] = 0;
      if (arb) begin
        w         = pickWinner(c, mode, model_ptr);
        model_cur = w;
        if (w >= 0) begin
          model_ptr = (w == 0) ? N - 1 : w - 1;
          if (rr_phase) begin
            for (int i = 0; i < N; i++) begin
              if (i == w) wait_cnt[i] = 0;
              else if (req[i]) begin
                wait_cnt[i]++;
                checks++;
                if (wait_cnt[i] > N - 1) begin
                  failures++;
                  $display("[TB] FAIL rr_starvation req%0d waited %0d grants, limit %0d", i, wait_cnt[i], N - 1);
                end
              end
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0]     exp_gnt;
      logic [IDX_W-1:0] exp_idx;
      exp_gnt = '0;
      exp_idx = '0;
      if (model_cur >= 0) begin
        exp_gnt[model_cur] = 1'b1;
        exp_idx = IDX_W'(model_cur);
      end
      checks++;
      if (gnt !== exp_gnt) begin
        failures++;
        $display("[TB] FAIL model_gnt t=%0t got %h expected %h", $time, gnt, exp_gnt);
      end
      checks++;
      if (gnt_idx !== exp_idx) begin
        failures++;
        $display("[TB] FAIL model_idx t=%0t got %0d expected %0d", $time, gnt_idx, exp_idx);
      end
      checks++;
      if (gnt_valid !== (model_cur >= 0)) begin
        failures++;
        $display("[TB] FAIL model_valid t=%0t got %b expected %b", $time, gnt_valid, model_cur >= 0);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        failures++;
        $display("[TB] FAIL onehot t=%0t got %b expected one-hot or zero", $time, gnt);
      end
    end
  end

  task automatic applyStimulus(input logic [N-1:0] r, input logic a, input logic m, input logic rn);
    req     = r;
    ack     = a;
    mode    = m;
    reset_n = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] exp_gnt, input logic [IDX_W-1:0] exp_idx);
    checks++;
    if (gnt !== exp_gnt || gnt_idx !== exp_idx || gnt_valid !== (exp_gnt != '0)) begin
      failures++;
      $display("[TB] FAIL %s got gnt=%h idx=%0d valid=%b expected gnt=%h idx=%0d valid=%b",
               name, gnt, gnt_idx, gnt_valid, exp_gnt, exp_idx, exp_gnt != '0);
    end
  endtask

  initial begin
    logic [N-1:0] r;
    logic         a;
    logic         m;
    logic         rn;

    req = '0; ack = 1'b0; mode = 1'b0; reset_n = 1'b0;

    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    checkOutput("t1_reset", 8'h00, 3'd0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_release", 8'h80, 3'd7);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_idle", 8'h00, 3'd0);

    applyStimulus(8'h26, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_first", 8'h20, 3'd5);
    applyStimulus(8'h26, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_hold", 8'h20, 3'd5);
    applyStimulus(8'h06, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_second", 8'h04, 3'd2);
    applyStimulus(8'h02, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_third", 8'h02, 3'd1);
    applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_idle", 8'h00, 3'd0);

    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h81, 1'b0, 1'b1, 1'b1);
    checkOutput("t3_rr0", 8'h80, 3'd7);
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_rr1", 8'h01, 3'd0);
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_rr2_wrap", 8'h80, 3'd7);
    applyStimulus(8'h81, 1'b1, 1'b1, 1'b1);
    checkOutput("t3_rr3", 8'h01, 3'd0);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h04, 1'b0, 1'b0, 1'b1);
      checkOutput("t4_hold", 8'h04, 3'd2);
    end
    applyStimulus(8'h84, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_no_preempt", 8'h04, 3'd2);
    applyStimulus(8'h80, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_drop", 8'h80, 3'd7);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);

    applyStimulus(8'h10, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_grant", 8'h10, 3'd4);
    applyStimulus(8'h58, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_mode_flip_hold", 8'h10, 3'd4);
    applyStimulus(8'h58, 1'b1, 1'b1, 1'b1);
    checkOutput("t5_rr_applies", 8'h08, 3'd3);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);

    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
    checkOutput("t6_grant", 8'h80, 3'd7);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_reset_mid_grant", 8'h00, 3'd0);

    r = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc == 5000) rr_phase = 1'b1;
      for (int b = 0; b < N; b++) if ($urandom_range(7, 0) == 0) r[b] = ~r[b];
      a = ($urandom_range(2, 0) == 0);
      if (a && model_cur >= 0 && $urandom_range(1, 0) == 0) r[model_cur] = 1'b0;
      if (rr_phase) begin
        m  = 1'b1;
        rn = 1'b1;
      end else begin
        m  = ($urandom_range(15, 0) == 0) ? ~mode : mode;
        rn = ($urandom_range(499, 0) != 0);
      end
      applyStimulus(r, a, m, rn);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
